// File: rtl/aes_ctrl_pkg.sv
// Shared types for the AES-128 multi-slot control path: scheduler states and the per-slot record.
package aes_ctrl_pkg;

  localparam int ROUNDS_AES128 = 10;
  // Wide enough for any round count up to 31; users slice down to their RND_W.
  localparam int REC_RND_W     = 5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } sched_state_t;

  typedef struct packed {
    logic                 valid;
    logic                 fin;
    logic [REC_RND_W-1:0] round;
  } slot_rec_t;

endpackage

// File: rtl/aes_slot_tracker.sv
// Per-slot {valid, fin, round} records plus the rotating slot pointer.
// Only the slot under the pointer is ever updated; all others hold.
module aes_slot_tracker
  import aes_ctrl_pkg::*;
#(
  parameter int SLOTS  = 4,
  parameter int ROUNDS = ROUNDS_AES128,
  parameter int SLOT_W = $clog2(SLOTS),
  parameter int RND_W  = $clog2(ROUNDS + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              advance,
  input  logic              load,
  input  logic              compute,
  input  logic              offload,
  output logic [SLOT_W-1:0] ptr,
  output logic              cur_valid,
  output logic              cur_fin,
  output logic              cur_last_round,
  output logic [RND_W-1:0]  cur_round,
  output logic              others_valid
);

  slot_rec_t         rec_arr [SLOTS];
  slot_rec_t         cur_rec;
  logic [SLOT_W-1:0] ptr_reg;
  logic [SLOTS-1:0]  other_valid_vec;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      ptr_reg <= '0;
    end else if (advance) begin
      ptr_reg <= ptr_reg + SLOT_W'(1);
    end
  end

  for (genvar gi = 0; gi < SLOTS; gi++) begin : g_slot
    slot_rec_t rec_reg;
    logic      sel;

    assign sel = (ptr_reg == SLOT_W'(gi));

    // A load on a slot being offloaded in the same cycle wins: the new block replaces it.
    always_ff @(posedge clk) begin
      if (rst || clear) begin
        rec_reg <= '0;
      end else if (sel) begin
        if (load) begin
          rec_reg <= '{valid: 1'b1, fin: 1'b0, round: REC_RND_W'(1)};
        end else if (offload) begin
          rec_reg.valid <= 1'b0;
        end else if (compute) begin
          if (rec_reg.round == REC_RND_W'(ROUNDS)) begin
            rec_reg.fin <= 1'b1;
          end else begin
            rec_reg.round <= rec_reg.round + REC_RND_W'(1);
          end
        end
      end
    end

    assign rec_arr[gi]         = rec_reg;
    assign other_valid_vec[gi] = rec_reg.valid & ~sel;
  end

  assign cur_rec        = rec_arr[ptr_reg];
  assign ptr            = ptr_reg;
  assign cur_valid      = cur_rec.valid;
  assign cur_fin        = cur_rec.fin;
  assign cur_last_round = (cur_rec.round == REC_RND_W'(ROUNDS));
  assign cur_round      = cur_rec.round[RND_W-1:0];
  assign others_valid   = |other_valid_vec;

endmodule

// File: rtl/aes_multi_slot_scheduler.sv
// Multi-slot AES-128 round scheduler: rotates over SLOTS blocks, issuing load/compute/offload strobes.
// Define RUN_CNT_EN to add the saturating 16-bit blk_count port.
module aes_multi_slot_scheduler
  import aes_ctrl_pkg::*;
#(
  parameter int SLOTS  = 4,
  parameter int ROUNDS = ROUNDS_AES128,
  parameter int SLOT_W = $clog2(SLOTS),
  parameter int RND_W  = $clog2(ROUNDS + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              enter_new_pair,
  input  logic              last_pair,
  input  logic              track_available,
  output logic              init,
  output logic              ok2load,
  output logic              ok2compute,
  output logic              final_round,
  output logic              perform_offload,
  output logic [SLOT_W-1:0] slot_sel,
  output logic [RND_W-1:0]  round_num,
  output logic              busy,
  output logic              done
`ifdef RUN_CNT_EN
  ,
  output logic [15:0]       blk_count
`endif
);

  sched_state_t      state_reg;
  logic              active;
  logic              finished;
  logic              stall;
  logic              advance;
  logic              clear;
  logic [SLOT_W-1:0] ptr;
  logic              cur_valid;
  logic              cur_fin;
  logic              cur_last_round;
  logic [RND_W-1:0]  cur_round;
  logic              others_valid;

  assign active          = (state_reg == ST_RUN) || (state_reg == ST_DRAIN);
  assign finished        = active & cur_valid & cur_fin;
  assign stall           = finished & ~track_available;
  assign perform_offload = finished & track_available;
  assign ok2compute      = active & cur_valid & ~cur_fin;
  assign final_round     = ok2compute & cur_last_round;
  assign ok2load         = (state_reg == ST_RUN) & enter_new_pair & (~cur_valid | perform_offload);
  assign advance         = active & ~stall;
  // Holding the tracker cleared outside RUN/DRAIN keeps ptr at 0 entering INIT.
  assign clear           = ~active;
  assign init            = (state_reg == ST_INIT);
  assign done            = (state_reg == ST_DONE);
  assign busy            = init | active;
  assign slot_sel        = busy ? ptr : '0;
  assign round_num       = busy ? cur_round : '0;

  aes_slot_tracker #(
    .SLOTS  (SLOTS),
    .ROUNDS (ROUNDS),
    .SLOT_W (SLOT_W),
    .RND_W  (RND_W)
  ) u_tracker (
    .clk            (clk),
    .rst            (rst),
    .clear          (clear),
    .advance        (advance),
    .load           (ok2load),
    .compute        (ok2compute),
    .offload        (perform_offload),
    .ptr            (ptr),
    .cur_valid      (cur_valid),
    .cur_fin        (cur_fin),
    .cur_last_round (cur_last_round),
    .cur_round      (cur_round),
    .others_valid   (others_valid)
  );

  // DRAIN ends on the edge that empties the last slot, so done follows the final offload directly.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      case (state_reg)
        ST_IDLE:  if (start) state_reg <= ST_INIT;
        ST_INIT:  state_reg <= ST_RUN;
        ST_RUN:   if (ok2load && last_pair) state_reg <= ST_DRAIN;
        ST_DRAIN: if (!others_valid && (!cur_valid || perform_offload)) state_reg <= ST_DONE;
        ST_DONE:  state_reg <= ST_IDLE;
        default:  state_reg <= ST_IDLE;
      endcase
    end
  end

`ifdef RUN_CNT_EN
  logic [15:0] blk_count_reg;

  always_ff @(posedge clk) begin
    if (rst || init) begin
      blk_count_reg <= '0;
    end else if (perform_offload && (blk_count_reg != 16'hFFFF)) begin
      blk_count_reg <= blk_count_reg + 16'd1;
    end
  end

  assign blk_count = blk_count_reg;
`endif

endmodule

// File: tb/tb_aes_multi_slot_scheduler.sv
// Scoreboard bench for aes_multi_slot_scheduler (SLOTS=4, ROUNDS=10) with a cycle-level reference model.
module tb_aes_multi_slot_scheduler;

  localparam int SLOTS  = 4;
  localparam int ROUNDS = 10;
  localparam int SW     = 2;
  localparam int RW     = 4;
  localparam int LAT    = SLOTS * (ROUNDS + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          enter_new_pair;
  logic          last_pair;
  logic          track_available;
  logic          init;
  logic          ok2load;
  logic          ok2compute;
  logic          final_round;
  logic          perform_offload;
  logic [SW-1:0] slot_sel;
  logic [RW-1:0] round_num;
  logic          busy;
  logic          done;
`ifdef RUN_CNT_EN
  logic [15:0]   blk_count;
`endif

  always #5 clk = ~clk;

  aes_multi_slot_scheduler #(
    .SLOTS  (SLOTS),
    .ROUNDS (ROUNDS)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .enter_new_pair  (enter_new_pair),
    .last_pair       (last_pair),
    .track_available (track_available),
    .init            (init),
    .ok2load         (ok2load),
    .ok2compute      (ok2compute),
    .final_round     (final_round),
    .perform_offload (perform_offload),
    .slot_sel        (slot_sel),
    .round_num       (round_num),
    .busy            (busy),
    .done            (done)
`ifdef RUN_CNT_EN
    ,
    .blk_count       (blk_count)
`endif
  );

  typedef struct {
    int slot;
    int due;
  } off_t;

  int   checks_cnt = 0;
  int   errors_cnt = 0;
  int   cyc        = 0;
  int   ph         = 0;  // 0 idle, 1 init, 2 run, 3 drain, 4 done
  bit   known      = 1'b0;
  bit   occ [SLOTS];
  int   ld_cyc [SLOTS];
  int   ptr_m      = 0;
  int   exp_cnt    = 0;
  int   nloads     = 0;
  int   l0         = 0;
  off_t offq [$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      errors_cnt++;
      $display("FAIL %s cycle %0d got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  // Inputs are already driven; sample 1ns later, compare against the model, then advance the model.
  task automatic step();
    bit   act, stl, e_cmp, e_fin, e_off, e_ld, e_init, e_busy, e_done, any_occ;
    int   s, k;
    off_t f;
    #1;
    act    = (ph == 2) || (ph == 3);
    s      = ptr_m;
    k      = occ[s] ? (cyc - ld_cyc[s]) / SLOTS : 0;
    e_cmp  = act && occ[s] && (k >= 1) && (k <= ROUNDS);
    e_fin  = e_cmp && (k == ROUNDS);
    e_off  = act && occ[s] && (k > ROUNDS) && track_available;
    stl    = act && occ[s] && (k > ROUNDS) && !track_available;
    e_ld   = (ph == 2) && enter_new_pair && (!occ[s] || e_off);
    e_init = (ph == 1);
    e_busy = (ph >= 1) && (ph <= 3);
    e_done = (ph == 4);
    if (known) begin
      check_val("strobes", 32'({init, ok2load, ok2compute, final_round, perform_offload, busy, done}),
                32'({e_init, e_ld, e_cmp, e_fin, e_off, e_busy, e_done}));
      if (act) check_val("slot_sel", 32'(slot_sel), 32'(s));
      if (e_cmp) check_val("round_num", 32'(round_num), 32'(k));
      if (!e_busy) check_val("sel_rnd_idle", 32'({slot_sel, round_num}), 32'(0));
`ifdef RUN_CNT_EN
      check_val("blk_count", 32'(blk_count), 32'(exp_cnt));
`endif
      if (perform_offload === 1'b1) begin
        if (offq.size() == 0) begin
          check_val("offload_unexpected", 32'(1), 32'(0));
        end else begin
          f = offq.pop_front();
          check_val("offload_slot", 32'(slot_sel), 32'(f.slot));
          check_val("offload_cycle", 32'(cyc), 32'(f.due));
        end
      end
    end
    // Model update.
    if (stl) begin
      for (int i = 0; i < SLOTS; i++) if (occ[i]) ld_cyc[i]++;
      foreach (offq[i]) offq[i].due++;
    end
    if (e_off) begin
      occ[s] = 1'b0;
      if (exp_cnt < 65535) exp_cnt++;
    end
    if (e_ld) begin
      occ[s]    = 1'b1;
      ld_cyc[s] = cyc;
      offq.push_back('{slot: s, due: cyc + LAT});
      nloads++;
    end
    if (act && !stl) ptr_m = (ptr_m + 1) % SLOTS;
    if (!act) ptr_m = 0;
    any_occ = 1'b0;
    for (int i = 0; i < SLOTS; i++) any_occ |= occ[i];
    case (ph)
      0: if (start) ph = 1;
      1: begin ph = 2; exp_cnt = 0; end
      2: if (e_ld && last_pair) ph = 3;
      3: if (!any_occ) ph = 4;
      default: ph = 0;
    endcase
    if (rst) begin
      ph = 0; ptr_m = 0; exp_cnt = 0;
      for (int i = 0; i < SLOTS; i++) occ[i] = 1'b0;
      offq.delete();
    end
    known = 1'b1;
    @(negedge clk);
    cyc++;
  endtask

  task automatic drive(input bit r, input bit st, input bit enp, input bit lst, input bit trk);
    rst = r; start = st; enter_new_pair = enp; last_pair = lst; track_available = trk;
    step();
  endtask

  task automatic begin_run();
    drive(0, 1, 0, 0, 1);
    drive(0, 0, 0, 0, 1);
  endtask

  initial begin
    for (int i = 0; i < SLOTS; i++) begin occ[i] = 1'b0; ld_cyc[i] = 0; end
    // Reset, then idle with noisy inputs that must be ignored.
    drive(1, 0, 0, 0, 0);
    drive(1, 0, 1, 1, 1);
    repeat (3) drive(0, 0, 1, 1, 1);
    // Single pair.
    begin_run();
    drive(0, 0, 1, 1, 1);
    repeat (50) drive(0, 0, 0, 0, 1);
    // Four back-to-back pairs.
    begin_run();
    for (int i = 0; i < 4; i++) drive(0, 0, 1, (i == 3), 1);
    repeat (50) drive(0, 0, 0, 0, 1);
    // Eight-pair continuous stream.
    begin_run();
    nloads = 0;
    for (int i = 0; i < 60 && ph == 2; i++) drive(0, 0, 1, (nloads == 7), 1);
    repeat (55) drive(0, 0, 0, 0, 1);
    // Downstream stall for 3 cycles when slot 1 is finished.
    begin_run();
    l0 = cyc;
    for (int i = 0; i < 4; i++) drive(0, 0, 1, (i == 3), 1);
    for (int i = 0; i < 60; i++) drive(0, 0, 0, 0, !(cyc >= l0 + LAT + 1 && cyc < l0 + LAT + 4));
    // Reset mid-run with two slots in flight, then a fresh run.
    begin_run();
    drive(0, 0, 1, 0, 1);
    drive(0, 0, 1, 0, 1);
    repeat (10) drive(0, 0, 0, 0, 1);
    drive(1, 0, 0, 0, 1);
    repeat (5) drive(0, 0, 1, 1, 1);
    begin_run();
    drive(0, 0, 1, 1, 1);
    repeat (50) drive(0, 0, 0, 0, 1);
    check_val("offq_drained", 32'(offq.size()), 32'(0));
    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
